// File: rtl/rc4_prga_decrypt.sv
// rtl/rc4_prga_decrypt.sv - RC4 PRGA keystream generator and ROM-to-RAM decryptor
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    output logic       o_finish,
    output logic [7:0] o_s_address,
    output logic [7:0] o_s_data,
    output logic       o_s_wen,
    input  logic [7:0] i_s_q,
    output logic [7:0] o_rom_address,
    input  logic [7:0] i_rom_q,
    output logic [7:0] o_ram_address,
    output logic [7:0] o_ram_data,
    output logic       o_ram_wen
);

    localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INC_I, S_WAIT_I, S_READ_I, S_ADDR_J, S_WAIT_J, S_READ_J,
        S_WR_I, S_WR_J, S_ADDR_F, S_WAIT_F, S_READ_F, S_WR_OUT, S_NEXT_K, S_DONE
    } state_t;

    state_t     r_state, w_state;
    logic [7:0] r_i, r_j, r_k, r_si, r_sj, r_f, r_enc;
    logic [7:0] w_i, w_j, w_k, w_si, w_sj, w_f, w_enc;
    logic [7:0] r_s_address, r_s_data, r_rom_address, r_ram_address, r_ram_data;
    logic [7:0] w_s_address, w_s_data, w_rom_address, w_ram_address, w_ram_data;
    logic       r_s_wen, r_ram_wen, r_finish;
    logic       w_s_wen, w_ram_wen, w_finish;

    // Register the FSM state, working registers and every output; reset aborts any pass.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_i           <= '0;
            r_j           <= '0;
            r_k           <= '0;
            r_si          <= '0;
            r_sj          <= '0;
            r_f           <= '0;
            r_enc         <= '0;
            r_s_address   <= '0;
            r_s_data      <= '0;
            r_s_wen       <= 1'b0;
            r_rom_address <= '0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_wen     <= 1'b0;
            r_finish      <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_i           <= w_i;
            r_j           <= w_j;
            r_k           <= w_k;
            r_si          <= w_si;
            r_sj          <= w_sj;
            r_f           <= w_f;
            r_enc         <= w_enc;
            r_s_address   <= w_s_address;
            r_s_data      <= w_s_data;
            r_s_wen       <= w_s_wen;
            r_rom_address <= w_rom_address;
            r_ram_address <= w_ram_address;
            r_ram_data    <= w_ram_data;
            r_ram_wen     <= w_ram_wen;
            r_finish      <= w_finish;
        end
    end

    // Next-state and next-register values; strobes default low so each lasts exactly one cycle.
    always_comb begin
        w_state       = r_state;
        w_i           = r_i;
        w_j           = r_j;
        w_k           = r_k;
        w_si          = r_si;
        w_sj          = r_sj;
        w_f           = r_f;
        w_enc         = r_enc;
        w_s_address   = r_s_address;
        w_s_data      = r_s_data;
        w_rom_address = r_rom_address;
        w_ram_address = r_ram_address;
        w_ram_data    = r_ram_data;
        w_s_wen       = 1'b0;
        w_ram_wen     = 1'b0;
        w_finish      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_i     = '0;
                    w_j     = '0;
                    w_k     = '0;
                    w_state = S_INC_I;
                end
            end
            S_INC_I: begin
                w_i         = r_i + 8'd1;
                w_s_address = r_i + 8'd1;
                w_state     = S_WAIT_I;
            end
            S_WAIT_I: w_state = S_READ_I;
            S_READ_I: begin
                w_si    = i_s_q;
                w_j     = r_j + i_s_q;
                w_state = S_ADDR_J;
            end
            S_ADDR_J: begin
                w_s_address = r_j;
                w_state     = S_WAIT_J;
            end
            S_WAIT_J: w_state = S_READ_J;
            S_READ_J: begin
                w_sj    = i_s_q;
                w_state = S_WR_I;
            end
            // When i==j both writes store the same byte, leaving S unchanged as RC4 expects.
            S_WR_I: begin
                w_s_address = r_i;
                w_s_data    = r_sj;
                w_s_wen     = 1'b1;
                w_state     = S_WR_J;
            end
            S_WR_J: begin
                w_s_address = r_j;
                w_s_data    = r_si;
                w_s_wen     = 1'b1;
                w_state     = S_ADDR_F;
            end
            S_ADDR_F: begin
                w_s_address   = r_si + r_sj;
                w_rom_address = r_k;
                w_state       = S_WAIT_F;
            end
            S_WAIT_F: w_state = S_READ_F;
            S_READ_F: begin
                w_f     = i_s_q;
                w_enc   = i_rom_q;
                w_state = S_WR_OUT;
            end
            S_WR_OUT: begin
                w_ram_address = r_k;
                w_ram_data    = r_f ^ r_enc;
                w_ram_wen     = 1'b1;
                w_state       = S_NEXT_K;
            end
            S_NEXT_K: begin
                if (r_k == LAST_K) begin
                    w_state = S_DONE;
                end else begin
                    w_k     = r_k + 8'd1;
                    w_state = S_INC_I;
                end
            end
            S_DONE: begin
                w_finish = 1'b1;
                w_state  = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign o_finish      = r_finish;
    assign o_s_address   = r_s_address;
    assign o_s_data      = r_s_data;
    assign o_s_wen       = r_s_wen;
    assign o_rom_address = r_rom_address;
    assign o_ram_address = r_ram_address;
    assign o_ram_data    = r_ram_data;
    assign o_ram_wen     = r_ram_wen;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// tb/tb_rc4_prga_decrypt.sv - self-checking bench for rc4_prga_decrypt
`timescale 1ns/1ps
module tb_rc4_prga_decrypt;

    localparam int LA = 9;
    localparam int LB = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start_a, start_b;
    logic       a_finish, a_s_wen, a_ram_wen, b_finish, b_s_wen, b_ram_wen;
    logic [7:0] a_s_address, a_s_data, a_s_q, a_rom_address, a_rom_q, a_ram_address, a_ram_data;
    logic [7:0] b_s_address, b_s_data, b_s_q, b_rom_address, b_rom_q, b_ram_address, b_ram_data;

    rc4_prga_decrypt #(.MSG_LEN(LA)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .o_finish(a_finish),
        .o_s_address(a_s_address), .o_s_data(a_s_data), .o_s_wen(a_s_wen), .i_s_q(a_s_q),
        .o_rom_address(a_rom_address), .i_rom_q(a_rom_q),
        .o_ram_address(a_ram_address), .o_ram_data(a_ram_data), .o_ram_wen(a_ram_wen)
    );

    rc4_prga_decrypt #(.MSG_LEN(LB)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .o_finish(b_finish),
        .o_s_address(b_s_address), .o_s_data(b_s_data), .o_s_wen(b_s_wen), .i_s_q(b_s_q),
        .o_rom_address(b_rom_address), .i_rom_q(b_rom_q),
        .o_ram_address(b_ram_address), .o_ram_data(b_ram_data), .o_ram_wen(b_ram_wen)
    );

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } sb_t;

    typedef struct {
        int              s_mode;
        int              rom_mode;
        logic [7:0]      fill;
        int              mid_at;
        int              nexp;
        logic [0:8][7:0] exp;
    } vec_t;

    logic [7:0] s_a [256];
    logic [7:0] rom_a [256];
    logic [7:0] ram_a [256];
    logic [7:0] s_b [256];
    logic [7:0] rom_b [256];
    logic [7:0] ram_b [256];
    logic [7:0] m_s [256];
    sb_t        q_a [$];
    sb_t        q_b [$];
    int         n_swen [2];
    int         n_ramwen [2];
    int         checks = 0;
    int         errors = 0;
    vec_t       vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: memory models act on the rising edge, monitors and scoreboard on the falling edge.
    task automatic tick();
        sb_t e;
        @(posedge clk);
        a_s_q   <= s_a[a_s_address];
        a_rom_q <= rom_a[a_rom_address];
        b_s_q   <= s_b[b_s_address];
        b_rom_q <= rom_b[b_rom_address];
        if (a_s_wen) s_a[a_s_address] = a_s_data;
        if (a_ram_wen) ram_a[a_ram_address] = a_ram_data;
        if (b_s_wen) s_b[b_s_address] = b_s_data;
        if (b_ram_wen) ram_b[b_ram_address] = b_ram_data;
        @(negedge clk);
        if (a_s_wen) n_swen[0]++;
        if (b_s_wen) n_swen[1]++;
        if (a_ram_wen) begin
            n_ramwen[0]++;
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_a_unexpected: got write %h=%h expected none", a_ram_address, a_ram_data);
            end else begin
                e = q_a.pop_front();
                check("sb_a_byte", {48'h0, a_ram_address, a_ram_data}, {48'h0, e.addr, e.data});
            end
        end
        if (b_ram_wen) begin
            n_ramwen[1]++;
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_b_unexpected: got write %h=%h expected none", b_ram_address, b_ram_data);
            end else begin
                e = q_b.pop_front();
                check("sb_b_byte", {48'h0, b_ram_address, b_ram_data}, {48'h0, e.addr, e.data});
            end
        end
    endtask

    task automatic init_mem(input bit sel, input int s_mode, input int rom_mode, input logic [7:0] fill);
        logic [7:0] t [256];
        logic [7:0] key [3];
        logic [7:0] ct [9];
        logic [7:0] j, x;
        int r;
        key = '{8'h4B, 8'h65, 8'h79};
        ct  = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
        for (int n = 0; n < 256; n++) t[n] = 8'(n);
        if (s_mode == 1) begin
            j = 8'h00;
            for (int n = 0; n < 256; n++) begin
                j = j + t[n] + key[n % 3];
                x = t[n]; t[n] = t[j]; t[j] = x;
            end
        end else if (s_mode == 2) begin
            for (int n = 255; n > 0; n--) begin
                r = int'($urandom_range(n, 0));
                x = t[n]; t[n] = t[r]; t[r] = x;
            end
        end
        for (int n = 0; n < 256; n++) begin
            m_s[n] = t[n];
            if (rom_mode == 0) x = fill;
            else if (rom_mode == 1) x = (n < 9) ? ct[n] : 8'h00;
            else x = 8'($urandom_range(255, 0));
            if (sel) begin s_b[n] = t[n]; rom_b[n] = x; ram_b[n] = 8'h00; end
            else     begin s_a[n] = t[n]; rom_a[n] = x; ram_a[n] = 8'h00; end
        end
    endtask

    // Reference RC4 PRGA on m_s; pushes expected RAM writes to the matching scoreboard queue.
    task automatic model_run(input bit sel, input int len);
        logic [7:0] i, j, t, idx, kb;
        sb_t e;
        i = 8'h00;
        j = 8'h00;
        for (int k = 0; k < len; k++) begin
            i = i + 8'd1;
            j = j + m_s[i];
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
            idx = m_s[i] + m_s[j];
            kb = 8'(k);
            e.addr = kb;
            e.data = m_s[idx] ^ (sel ? rom_b[kb] : rom_a[kb]);
            if (sel) q_b.push_back(e); else q_a.push_back(e);
        end
    endtask

    function automatic int s_mismatch(input bit sel);
        int m = 0;
        for (int n = 0; n < 256; n++) if ((sel ? s_b[n] : s_a[n]) !== m_s[n]) m++;
        return m;
    endfunction

    task automatic check_after(input bit sel, input int len, input string tag);
        check({tag, " s_wen_count"}, 64'(n_swen[sel]), 64'(2 * len));
        check({tag, " ram_wen_count"}, 64'(n_ramwen[sel]), 64'(len));
        check({tag, " queue_left"}, 64'(sel ? q_b.size() : q_a.size()), 64'd0);
        check({tag, " s_final_mismatches"}, 64'(s_mismatch(sel)), 64'd0);
    endtask

    task automatic run_pass(input bit sel, input int len, input int mid_at, input string tag);
        int c;
        bit seen;
        n_swen[sel] = 0;
        n_ramwen[sel] = 0;
        start_a = !sel;
        start_b = sel;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        c = 0;
        seen = 1'b0;
        while (c < 6000 && !seen) begin
            if (mid_at > 0 && c == mid_at) begin
                start_a = !sel;
                start_b = sel;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            tick();
            c++;
            seen = sel ? b_finish : a_finish;
        end
        start_a = 1'b0;
        start_b = 1'b0;
        check({tag, " latency"}, 64'(c), 64'(13 * len + 1));
        tick();
        check({tag, " finish_one_cycle"}, {63'h0, sel ? b_finish : a_finish}, 64'd0);
        check_after(sel, len, tag);
    endtask

    initial begin
        int c;
        vecs[0] = '{0, 0, 8'h00, 0,  3, {8'h02, 8'h05, 8'h07, 48'h0}};
        vecs[1] = '{0, 0, 8'hFF, 50, 3, {8'hFD, 8'hFA, 8'hF8, 48'h0}};
        vecs[2] = '{1, 1, 8'h00, 0,  9, {8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74}};
        vecs[3] = '{2, 2, 8'h00, 77, 0, 72'h0};
        vecs[4] = '{0, 0, 8'h5A, 0,  3, {8'h58, 8'h5F, 8'h5D, 48'h0}};

        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        init_mem(0, 0, 0, 8'h00);
        init_mem(1, 0, 0, 8'h00);
        tick();
        tick();
        check("reset_outputs_a", {21'h0, a_finish, a_s_address, a_s_data, a_s_wen,
              a_rom_address, a_ram_address, a_ram_data, a_ram_wen}, 64'd0);
        check("reset_outputs_b", {21'h0, b_finish, b_s_address, b_s_data, b_s_wen,
              b_rom_address, b_ram_address, b_ram_data, b_ram_wen}, 64'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            init_mem(0, vecs[v].s_mode, vecs[v].rom_mode, vecs[v].fill);
            model_run(0, LA);
            run_pass(0, LA, vecs[v].mid_at, $sformatf("vec%0d", v));
            for (int n = 0; n < vecs[v].nexp; n++)
                check($sformatf("vec%0d ram[%0d]", v, n), {56'h0, ram_a[n]}, {56'h0, vecs[v].exp[n]});
        end

        // Reset during the fifth byte, then a fresh pass must start again from k=0.
        init_mem(0, 1, 1, 8'h00);
        model_run(0, LA);
        n_ramwen[0] = 0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (57) tick();
        check("midreset bytes_before", 64'(n_ramwen[0]), 64'd4);
        rst_n = 1'b0;
        #1;
        check("midreset outputs", {21'h0, a_finish, a_s_address, a_s_data, a_s_wen,
              a_rom_address, a_ram_address, a_ram_data, a_ram_wen}, 64'd0);
        q_a.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        init_mem(0, 1, 1, 8'h00);
        model_run(0, LA);
        run_pass(0, LA, 0, "after_reset");
        check("after_reset ram0", {56'h0, ram_a[0]}, 64'h50);
        check("after_reset ram8", {56'h0, ram_a[8]}, 64'h74);

        // Start held high: second pass follows the finish pulse with no idle gap.
        init_mem(0, 0, 0, 8'h00);
        model_run(0, LA);
        model_run(0, LA);
        n_swen[0] = 0;
        n_ramwen[0] = 0;
        start_a = 1'b1;
        tick();
        c = 0;
        while (c < 6000 && !a_finish) begin tick(); c++; end
        check("held first_latency", 64'(c), 64'(13 * LA + 1));
        tick();
        check("held finish_one_cycle", {63'h0, a_finish}, 64'd0);
        start_a = 1'b0;
        c = 1;
        while (c < 6000 && !a_finish) begin tick(); c++; end
        check("held restart_gap", 64'(c), 64'(13 * LA + 2));
        tick();
        check_after(0, 2 * LA, "held");

        // Full 256-byte pass: k reaches 255 and i wraps back to 0.
        init_mem(1, 2, 2, 8'h00);
        model_run(1, LB);
        run_pass(1, LB, 1000, "len256");
        repeat (3) tick();
        check("len256 idle_after", {62'h0, b_finish, b_ram_wen}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
